// File: rtl/ifetch_queue_if.sv
// ----------------------------------------------------------------------------
// ifetch_queue_if
// Bundle of the instruction-fetch queue's bus signals.
//   im_req / im_addr          : fetch request toward instruction memory
//   im_ack / im_rdata         : memory response for the outstanding request
//   redirect / redirect_pc    : restart request from the next-PC logic
//   inst_valid/inst/inst_pc   : head of queue offered to decode
//   inst_ready                : decode accepts the head entry
// master : the fetch queue itself
// slave  : the environment (memory, next-PC logic and decode stage)
// ----------------------------------------------------------------------------
interface ifetch_queue_if;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ack;
   logic [31:0] im_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;

   modport master (
      output im_req, im_addr, inst_valid, inst, inst_pc,
      input  im_ack, im_rdata, redirect, redirect_pc, inst_ready
   );

   modport slave (
      input  im_req, im_addr, inst_valid, inst, inst_pc,
      output im_ack, im_rdata, redirect, redirect_pc, inst_ready
   );
endinterface

// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
// Instruction prefetch queue. Issues sequential word fetches (one request
// outstanding at most), buffers returned words with their PCs in a DEPTH-entry
// FIFO and offers the head to decode via valid/ready. A redirect flushes the
// queue and restarts fetching at the new target; a request already in flight
// when the redirect arrives is allowed to complete and its word is dropped.
// Ports:
//   clk : clock, all state on rising edge
//   rst : asynchronous active-low reset
//   bus : ifetch_queue_if.master (memory, redirect and decode signals)
// ----------------------------------------------------------------------------
module ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic           clk,
   input  logic           rst,
   ifetch_queue_if.master bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t             state_r, state_s;
   logic [31:0]        fetch_pc_r, fetch_pc_s;
   logic [31:0]        im_addr_r, im_addr_s;
   logic [31:0]        mem_data_r [DEPTH];
   logic [31:0]        mem_pc_r   [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_r, wr_ptr_r;
   logic [CNT_W-1:0]   count_r;
   logic [CNT_W-1:0]   count_next_s;
   logic [31:0]        target_s;
   logic [31:0]        pc_inc_s;
   logic               pop_s, push_s, flush_s;

   // Decode-side handshake and helper values used by the FSM
   always_comb begin
      pop_s        = (count_r != {CNT_W{1'b0}}) & bus.inst_ready;
      target_s     = bus.redirect_pc & ~32'h0000_0003;
      pc_inc_s     = fetch_pc_r + 32'd4;
      // occupancy after a push this cycle, honouring a simultaneous pop
      count_next_s = count_r + CNT_W'(1) - {{(CNT_W-1){1'b0}}, pop_s};
   end

   // Fetch FSM: next state, next fetch address and FIFO push/flush controls
   always_comb begin
      state_s    = state_r;
      fetch_pc_s = fetch_pc_r;
      im_addr_s  = im_addr_r;
      push_s     = 1'b0;
      flush_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.redirect) begin
               flush_s    = 1'b1;
               fetch_pc_s = target_s;
               im_addr_s  = target_s;
               state_s    = BUSY;
            end else if ((count_r < DEPTH_C) || pop_s) begin
               // a pop from a full queue frees a slot at this edge
               im_addr_s = fetch_pc_r;
               state_s   = BUSY;
            end else begin
               state_s = IDLE;
            end
         end
         BUSY: begin
            if (bus.redirect) begin
               flush_s    = 1'b1;
               fetch_pc_s = target_s;
               if (bus.im_ack) begin
                  im_addr_s = target_s;
                  state_s   = BUSY;
               end else begin
                  // old request still in flight; its word must be dropped
                  state_s = DISCARD;
               end
            end else if (bus.im_ack) begin
               push_s     = 1'b1;
               fetch_pc_s = pc_inc_s;
               if (count_next_s < DEPTH_C) begin
                  im_addr_s = pc_inc_s;
                  state_s   = BUSY;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               state_s = BUSY;
            end
         end
         DISCARD: begin
            if (bus.redirect) begin
               flush_s    = 1'b1;
               fetch_pc_s = target_s;
               if (bus.im_ack) begin
                  im_addr_s = target_s;
                  state_s   = BUSY;
               end else begin
                  state_s = DISCARD;
               end
            end else if (bus.im_ack) begin
               im_addr_s = fetch_pc_r;
               state_s   = BUSY;
            end else begin
               state_s = DISCARD;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // FSM state, fetch PC and request address registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= IDLE;
         fetch_pc_r <= RESET_PC;
         im_addr_r  <= RESET_PC;
      end else begin
         state_r    <= state_s;
         fetch_pc_r <= fetch_pc_s;
         im_addr_r  <= im_addr_s;
      end
   end

   // FIFO pointers and occupancy; a flush overrides push and pop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (flush_s) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // FIFO storage: instruction word and its PC
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_data_r[i] <= 32'h0000_0000;
            mem_pc_r[i]   <= 32'h0000_0000;
         end
      end else if (push_s && !flush_s) begin
         mem_data_r[wr_ptr_r] <= bus.im_rdata;
         mem_pc_r[wr_ptr_r]   <= fetch_pc_r;
      end
   end

   // Outputs come from registered state and storage only
   always_comb begin
      bus.im_req     = (state_r != IDLE);
      bus.im_addr    = im_addr_r;
      bus.inst_valid = (count_r != {CNT_W{1'b0}});
      if (bus.inst_valid) begin
         bus.inst    = mem_data_r[rd_ptr_r];
         bus.inst_pc = mem_pc_r[rd_ptr_r];
      end else begin
         bus.inst    = 32'h0000_0000;
         bus.inst_pc = 32'h0000_0000;
      end
   end

endmodule
